// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl_pkg
// Description : Shared definitions for the instruction-fetch front end:
//               fetch state encoding and the instruction word width.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_fetch_ctrl_pkg;

    localparam int INSTR_WIDTH = 32;

    // RUN  : fetching sequentially and delivering to decode
    // HALT : fetch stopped on a fault, waiting for a legal redirect
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage : imem_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry FIFO holding fetched {PC, instruction} pairs.
//               Entry 0 is always the head; a pop shifts entry 1 down.
// Ports       : clk, rst_n          - clock, async active-low reset
//               flush_i            - discard all entries (wins over push)
//               push_i/push_*_i    - write one {pc, instr} pair
//               pop_i              - remove the head (only when count_o != 0)
//               count_o            - number of valid entries (0..2)
//               head_pc_o/instr_o  - head entry payload
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [PC_WIDTH-1:0]    push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    input  logic                   pop_i,
    output logic [1:0]             count_o,
    output logic [PC_WIDTH-1:0]    head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o
);

    logic [PC_WIDTH-1:0]    pc_q    [2];
    logic [PC_WIDTH-1:0]    pc_d    [2];
    logic [INSTR_WIDTH-1:0] instr_q [2];
    logic [INSTR_WIDTH-1:0] instr_d [2];
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic [1:0]             w_kept;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        // entries surviving the pop; a push lands right behind them
        w_kept  = count_q - {1'b0, pop_i};
        if (pop_i) begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
        end
        if (push_i) begin
            pc_d[w_kept[0]]    = push_pc_i;
            instr_d[w_kept[0]] = push_instr_i;
        end
        count_d = w_kept + {1'b0, push_i};
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_pc_o    = pc_q[0];
    assign head_instr_o = instr_q[0];

endmodule : fetch_buf
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction fetch controller. Issues word reads to a
//               synchronous-read instruction memory (one cycle latency),
//               buffers responses in a 2-entry FIFO and hands instructions
//               to decode with a valid/ready handshake. Redirects flush the
//               pipeline; illegal targets or running off the end of memory
//               halt fetch with a sticky fault.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               redirect_valid/redirect_pc - load new fetch byte address
//               mem_req/mem_addr/mem_rdata - instruction memory interface
//               out_valid/out_ready        - decode handshake
//               out_pc/out_instr           - delivered instruction and PC
//               out_fault                  - fetch halted on fault
// Note        : PC_WIDTH must exceed ADDR_WIDTH+2.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  ADDR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   out_fault
);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  resp_epoch_q, resp_epoch_d;
    logic                  epoch_q, epoch_d;

    logic [1:0]            w_count;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_pc_oob;
    logic                  w_redirect_bad;
    logic [2:0]            w_occupancy;

    // fetch_pc beyond the last word means sequential fetch has run off the end
    assign w_pc_oob       = |fetch_pc_q[PC_WIDTH-1:ADDR_WIDTH+2];
    assign w_redirect_bad = (|redirect_pc[1:0]) || (|redirect_pc[PC_WIDTH-1:ADDR_WIDTH+2]);

    assign w_out_valid = (state_q == RUN) && (w_count != 2'd0);
    assign w_pop       = w_out_valid && out_ready;

    // Space check counts the in-flight word, credited by this cycle's pop,
    // so the FIFO can never overflow when the response lands.
    assign w_occupancy = {1'b0, w_count} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue     = (state_q == RUN) && !redirect_valid && !w_pc_oob
                         && (w_occupancy < 3'd2);

    // A response is kept only if no redirect has happened since it was issued.
    assign w_push = inflight_q && (resp_epoch_q == epoch_q) && !redirect_valid;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = w_issue;
        resp_epoch_d = epoch_q;
        epoch_d      = epoch_q;
        if (redirect_valid) begin
            epoch_d    = ~epoch_q;
            fetch_pc_d = redirect_pc;
            state_d    = w_redirect_bad ? HALT : RUN;
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            end
            // end of memory reached and everything delivered: stop with fault
            if ((state_q == RUN) && w_pc_oob && (w_count == 2'd0) && !inflight_q) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 1'b0;
            resp_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            resp_epoch_q <= resp_epoch_d;
            epoch_q      <= epoch_d;
        end
    end

    fetch_buf #(
        .PC_WIDTH (PC_WIDTH)
    ) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (w_push),
        .push_pc_i    (fetch_pc_q - PC_WIDTH'(4)),
        .push_instr_i (mem_rdata),
        .pop_i        (w_pop),
        .count_o      (w_count),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr)
    );

    // the request is combinational so it can fire in the first cycle out of
    // reset; gating with rst_n keeps it quiet while reset is held
    assign mem_req   = w_issue && rst_n;
    assign mem_addr  = fetch_pc_q[ADDR_WIDTH+1:2];
    assign out_valid = w_out_valid;
    assign out_fault = (state_q == HALT);

endmodule : imem_fetch_ctrl
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Self-checking bench for imem_fetch_ctrl. Instance A uses the
//               default parameters and is compared every cycle against a
//               queue-based reference; instance B (ADDR_WIDTH=4,
//               RESET_PC=0x38) exercises the end-of-memory halt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int AW = 10;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_ready;

    logic        mem_req_a, out_valid_a, out_fault_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] rdata_a, out_instr_a;
    logic [63:0] out_pc_a;

    logic        mem_req_b, out_valid_b, out_fault_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] rdata_b, out_instr_b;
    logic [63:0] out_pc_b;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_ctrl u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .mem_req (mem_req_a), .mem_addr (mem_addr_a), .mem_rdata (rdata_a),
        .out_valid (out_valid_a), .out_ready (out_ready),
        .out_pc (out_pc_a), .out_instr (out_instr_a), .out_fault (out_fault_a)
    );

    imem_fetch_ctrl #(.PC_WIDTH(64), .ADDR_WIDTH(4), .RESET_PC(64'h38)) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .redirect_valid (1'b0), .redirect_pc (64'h0),
        .mem_req (mem_req_b), .mem_addr (mem_addr_b), .mem_rdata (rdata_b),
        .out_valid (out_valid_b), .out_ready (1'b1),
        .out_pc (out_pc_b), .out_instr (out_instr_b), .out_fault (out_fault_b)
    );

    // instruction memories: word i holds 0x1000_0000 + i, one-cycle read
    always @(posedge clk) begin
        rdata_a <= mem_req_a ? (32'h1000_0000 + {22'b0, mem_addr_a}) : 32'hDEAD_BEEF;
        rdata_b <= mem_req_b ? (32'h1000_0000 + {28'b0, mem_addr_b}) : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return 32'h1000_0000 + {22'b0, pc[11:2]};
    endfunction

    function automatic bit bad_target(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || ((pc >> (AW + 2)) != 64'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    logic [63:0] m_pc, m_infl_pc;
    bit          m_infl, m_halt;
    logic [63:0] mq[$];
    logic [63:0] dlv[$];
    int          dlv_cyc[$];
    int          cyc;
    bit          e_valid, e_pop, e_oob, e_req, e_drained;
    int          e_occ;

    function automatic logic [63:0] dlv_at(input int i);
        return (i >= 0 && i < dlv.size()) ? dlv[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mem_req",   mem_req_a,   0);
            chk("rst_out_valid", out_valid_a, 0);
            chk("rst_out_fault", out_fault_a, 0);
            chk("rst_out_pc",    out_pc_a,    0);
            chk("rst_out_instr", out_instr_a, 0);
            m_pc = 64'h0; m_infl = 1'b0; m_halt = 1'b0; mq.delete(); cyc = 0;
        end else begin
            cyc++;
            e_valid = !m_halt && (mq.size() > 0);
            e_pop   = e_valid && out_ready;
            e_oob   = (m_pc >> (AW + 2)) != 64'd0;
            e_occ   = mq.size() + (m_infl ? 1 : 0) - (e_pop ? 1 : 0);
            e_req   = !m_halt && !redirect_valid && !e_oob && (e_occ < 2);
            chk("mem_req", mem_req_a, e_req);
            if (e_req) chk("mem_addr", mem_addr_a, (m_pc >> 2) & 64'h3FF);
            chk("out_valid", out_valid_a, e_valid);
            chk("out_fault", out_fault_a, m_halt);
            if (e_valid) begin
                chk("out_pc",    out_pc_a,    mq[0]);
                chk("out_instr", out_instr_a, word_of(mq[0]));
            end
            if (out_valid_a && out_ready) begin
                dlv.push_back(out_pc_a);
                dlv_cyc.push_back(cyc);
            end
            if (redirect_valid) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc;
                m_halt = bad_target(redirect_pc);
            end else begin
                e_drained = !m_halt && e_oob && (mq.size() == 0) && !m_infl;
                if (e_pop) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                m_infl_pc = m_pc;
                m_infl    = e_req;
                if (e_req) m_pc = m_pc + 64'd4;
                if (e_drained) m_halt = 1'b1;
            end
        end
    end

    // ---------------- instance B: end-of-memory halt ----------------
    logic [63:0] b_pcs[$];
    int          b_reqs = 0;
    int          b_fault_cyc = 0;
    bit          b_wrap = 1'b0;

    initial begin
        @(posedge rst_n);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid_b) begin
                b_pcs.push_back(out_pc_b);
                chk("b_instr", out_instr_b, word_of(out_pc_b));
            end
            if (mem_req_b) begin
                b_reqs++;
                if (mem_addr_b == 4'd0) b_wrap = 1'b1;
            end
            if (out_fault_b && b_fault_cyc == 0) b_fault_cyc = k;
        end
        chk("b_deliver_count", b_pcs.size(), 2);
        chk("b_pc0", (b_pcs.size() > 0) ? b_pcs[0] : 64'hFFFF, 64'h38);
        chk("b_pc1", (b_pcs.size() > 1) ? b_pcs[1] : 64'hFFFF, 64'h3C);
        chk("b_req_count", b_reqs, 2);
        chk("b_no_wrap", b_wrap, 0);
        chk("b_fault_cycle", b_fault_cyc, 6);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n0, n1, n2, n3;

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b1;
        step(3);
        chk("lit_reset_mem_req", mem_req_a, 0);
        chk("lit_reset_out_pc",  out_pc_a,  0);
        rst_n = 1'b1;
        #1;
        chk("lit_first_req",  mem_req_a,  1);
        chk("lit_first_addr", mem_addr_a, 0);

        // streaming with out_ready high: valid from cycle 3, no bubbles
        step(12);
        chk("lit_first_valid_cycle", (dlv_cyc.size() > 0) ? dlv_cyc[0] : -1, 3);
        chk("lit_tenth_valid_cycle", (dlv_cyc.size() > 9) ? dlv_cyc[9] : -1, 12);
        chk("lit_stream_count", dlv.size(), 10);

        // back-pressure for 5 cycles
        out_ready = 1'b0;
        step(5);
        chk("lit_stall_mem_req",   mem_req_a,   0);
        chk("lit_stall_out_valid", out_valid_a, 1);
        out_ready = 1'b1;
        step(8);
        for (int i = 0; i < dlv.size(); i++) chk("lit_seq_pc", dlv[i], 64'(4 * i));

        // redirect while a request is in flight and an entry is buffered
        n0 = dlv.size();
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("lit_redir_valid_low", out_valid_a, 0);
        out_ready = 1'b1;
        step(6);
        chk("lit_redir_pc0", dlv_at(n0),     64'h40);
        chk("lit_redir_pc1", dlv_at(n0 + 1), 64'h44);

        // redirect coincident with a pop: the pop completes
        n1 = dlv.size();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        step(1);
        redirect_valid = 1'b0;
        step(5);
        chk("lit_coinc_pop", dlv_at(n1), dlv_at(n1 - 1) + 64'd4);
        chk("lit_coinc_redir", dlv_at(n1 + 1), 64'h100);

        // misaligned redirect halts; legal redirect recovers
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        step(1);
        redirect_valid = 1'b0;
        chk("lit_fault_set",      out_fault_a, 1);
        chk("lit_fault_mem_req",  mem_req_a,   0);
        chk("lit_fault_valid",    out_valid_a, 0);
        step(4);
        chk("lit_fault_sticky",   out_fault_a, 1);
        chk("lit_fault_mem_req2", mem_req_a,   0);
        n2 = dlv.size();
        redirect_valid = 1'b1; redirect_pc = 64'h80;
        step(1);
        redirect_valid = 1'b0;
        chk("lit_fault_clear", out_fault_a, 0);
        step(4);
        chk("lit_recover_pc", dlv_at(n2), 64'h80);

        // target beyond memory halts as well
        redirect_valid = 1'b1; redirect_pc = 64'h1000;
        step(1);
        chk("lit_oob_fault", out_fault_a, 1);
        redirect_pc = 64'h200;
        step(1);
        redirect_valid = 1'b0;
        chk("lit_oob_clear", out_fault_a, 0);
        step(4);

        // asynchronous reset with a request in flight
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("lit_async_mem_req",   mem_req_a,   0);
        chk("lit_async_out_valid", out_valid_a, 0);
        chk("lit_async_out_pc",    out_pc_a,    0);
        chk("lit_async_out_instr", out_instr_a, 0);
        chk("lit_async_out_fault", out_fault_a, 0);
        @(posedge clk);
        #1;
        n3 = dlv.size();
        rst_n = 1'b1;
        #1;
        chk("lit_rerelease_req",  mem_req_a,  1);
        chk("lit_rerelease_addr", mem_addr_a, 0);
        step(5);
        chk("lit_rerelease_pc", dlv_at(n3), 64'h0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_fetch_ctrl
`default_nettype wire
